// File: rtl/fp_int_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fp_int_pkg                                                      |
// | Brief    : Shared states, exponent thresholds and helpers for fp_int_arb.  |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package fp_int_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLASS = 3'd1,
        ST_CONV  = 3'd2,
        ST_CAPT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CL_SAT    = 2'd0,
        CL_ZERO   = 2'd1,
        CL_DIRECT = 2'd2,
        CL_CONV   = 2'd3
    } fp_class_t;

    localparam logic [7:0]  C_EXP_ONE       = 8'd127;
    localparam logic [7:0]  C_EXP_DIRECT_LO = 8'd150;
    localparam logic [7:0]  C_EXP_DIRECT_HI = 8'd157;
    localparam logic [7:0]  C_EXP_SAT       = 8'd158;
    localparam logic [7:0]  C_EXP_INF       = 8'd255;

    localparam logic [31:0] C_SAT_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] C_SAT_NEG = 32'h8000_0000;

    // Exponents 151..157 only need a left shift of the significand, so they
    // skip the shared converter entirely.
    function automatic fp_class_t fp_classify(input logic [7:0] exp);
        fp_class_t cls;
        if ((exp == C_EXP_INF) || (exp >= C_EXP_SAT)) begin
            cls = CL_SAT;
        end else if (exp < C_EXP_ONE) begin
            cls = CL_ZERO;
        end else if ((exp > C_EXP_DIRECT_LO) && (exp <= C_EXP_DIRECT_HI)) begin
            cls = CL_DIRECT;
        end else begin
            cls = CL_CONV;
        end
        return cls;
    endfunction

    function automatic logic [31:0] apply_sign(input logic neg, input logic [31:0] mag);
        return neg ? (~mag + 32'd1) : mag;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_arb                                                          |
// | Brief    : Combinational round-robin picker: lowest request at/after ptr.  |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_arb #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic             o_valid
);

    localparam logic [N-1:0] C_ONE = N'(1);

    logic [N-1:0] w_below;
    logic [N-1:0] w_masked;
    logic [N-1:0] w_pick;

    // Requests at or above the pointer win first; otherwise wrap to the bottom.
    assign w_below  = (C_ONE << i_ptr) - C_ONE;
    assign w_masked = i_req & ~w_below;
    assign w_pick   = (|w_masked) ? w_masked : i_req;
    assign o_grant  = w_pick & (~w_pick + C_ONE);
    assign o_valid  = |i_req;

endmodule
`default_nettype wire

// File: rtl/fp_int_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fp_int_arb                                                      |
// | Brief    : Round-robin front end sharing one float->int magnitude          |
// |            converter between N_REQ requesters, with bypass classes.        |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module fp_int_arb
    import fp_int_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int CONV_LAT = 10
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [N_REQ-1:0]                           req_valid_i,
    input  logic [32*N_REQ-1:0]                        req_data_i,
    output logic [N_REQ-1:0]                           req_ready_o,
    output logic                                       rsp_valid_o,
    input  logic                                       rsp_ready_i,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] rsp_id_o,
    output logic [31:0]                                rsp_data_o,
    output logic                                       rsp_sat_o,
    output logic                                       cvt_en_o,
    output logic [31:0]                                cvt_din_o,
    input  logic [31:0]                                cvt_dout_i,
    output logic                                       busy_o
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [7:0] C_CNT_LAST = 8'(CONV_LAT - 1);

    state_t          r_state, w_state_nxt;
    logic [ID_W-1:0] r_ptr, w_ptr_nxt;
    logic [7:0]      r_cnt, w_cnt_nxt;
    logic [31:0]     r_operand, w_operand_nxt;
    logic [ID_W-1:0] r_id, w_id_nxt;
    logic [31:0]     r_result, w_result_nxt;
    logic            r_sat, w_sat_nxt;

    logic [N_REQ-1:0] w_grant;
    logic             w_gnt_valid;
    logic             w_accept;
    logic [ID_W-1:0]  w_grant_id;
    logic [31:0]      w_sel_data;
    logic [7:0]       w_exp;
    logic             w_sign;
    logic [31:0]      w_sig;
    logic [7:0]       w_shamt;

    rr_arb #(
        .N     (N_REQ),
        .PTR_W (ID_W)
    ) u_rr_arb (
        .i_req   (req_valid_i),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_valid (w_gnt_valid)
    );

    // Gating with rst_i keeps the accept strobe quiet while reset is held.
    assign w_accept = (r_state == ST_IDLE) && w_gnt_valid && rst_i;

    always_comb begin
        w_grant_id = '0;
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_grant_id = ID_W'(i);
                w_sel_data = req_data_i[32*i +: 32];
            end
        end
    end

    assign w_sign  = r_operand[31];
    assign w_exp   = r_operand[30:23];
    assign w_sig   = {8'h00, 1'b1, r_operand[22:0]};
    assign w_shamt = w_exp - C_EXP_DIRECT_LO;

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_operand_nxt = r_operand;
        w_id_nxt      = r_id;
        w_result_nxt  = r_result;
        w_sat_nxt     = r_sat;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_operand_nxt = w_sel_data;
                    w_id_nxt      = w_grant_id;
                    w_state_nxt   = ST_CLASS;
                end
            end
            ST_CLASS: begin
                case (fp_classify(w_exp))
                    CL_SAT: begin
                        w_result_nxt = w_sign ? C_SAT_NEG : C_SAT_POS;
                        w_sat_nxt    = 1'b1;
                        w_state_nxt  = ST_RESP;
                    end
                    CL_ZERO: begin
                        w_result_nxt = '0;
                        w_sat_nxt    = 1'b0;
                        w_state_nxt  = ST_RESP;
                    end
                    CL_DIRECT: begin
                        w_result_nxt = apply_sign(w_sign, w_sig << w_shamt);
                        w_sat_nxt    = 1'b0;
                        w_state_nxt  = ST_RESP;
                    end
                    default: begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_CONV;
                    end
                endcase
            end
            ST_CONV: begin
                if (r_cnt == C_CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_CAPT;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            ST_CAPT: begin
                w_result_nxt = apply_sign(w_sign, cvt_dout_i);
                w_sat_nxt    = 1'b0;
                w_state_nxt  = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    w_ptr_nxt   = (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + ID_W'(1);
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_operand <= '0;
            r_id      <= '0;
            r_result  <= '0;
            r_sat     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_operand <= w_operand_nxt;
            r_id      <= w_id_nxt;
            r_result  <= w_result_nxt;
            r_sat     <= w_sat_nxt;
        end
    end

    // Every output decodes straight from the state register, so reset clears them at once.
    assign req_ready_o = w_accept ? w_grant : '0;
    assign busy_o      = (r_state != ST_IDLE);
    assign cvt_en_o    = (r_state == ST_CONV);
    assign cvt_din_o   = cvt_en_o ? r_operand : '0;
    assign rsp_valid_o = (r_state == ST_RESP);
    assign rsp_data_o  = rsp_valid_o ? r_result : '0;
    assign rsp_id_o    = rsp_valid_o ? r_id : '0;
    assign rsp_sat_o   = rsp_valid_o & r_sat;

endmodule
`default_nettype wire

// File: tb/tb_fp_int_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fp_int_arb                                                   |
// | Brief    : Directed self-checking bench for fp_int_arb.                    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fp_int_arb;

    localparam int N_REQ    = 4;
    localparam int CONV_LAT = 10;

    logic                   clk_i = 1'b0;
    logic                   rst_i = 1'b0;
    logic [N_REQ-1:0]       req_valid_i = '0;
    logic [32*N_REQ-1:0]    req_data_i = '0;
    logic [N_REQ-1:0]       req_ready_o;
    logic                   rsp_valid_o;
    logic                   rsp_ready_i = 1'b0;
    logic [1:0]             rsp_id_o;
    logic [31:0]            rsp_data_o;
    logic                   rsp_sat_o;
    logic                   cvt_en_o;
    logic [31:0]            cvt_din_o;
    logic [31:0]            cvt_dout_i;
    logic                   busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    fp_int_arb #(
        .N_REQ    (N_REQ),
        .CONV_LAT (CONV_LAT)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_id_o    (rsp_id_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_sat_o   (rsp_sat_o),
        .cvt_en_o    (cvt_en_o),
        .cvt_din_o   (cvt_din_o),
        .cvt_dout_i  (cvt_dout_i),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Converter stand-in: truncated magnitude for exponents 127..150.
    function automatic logic [31:0] conv_mag(input logic [31:0] d);
        logic [7:0]  e;
        logic [31:0] m;
        e = d[30:23];
        m = {8'h00, 1'b1, d[22:0]};
        return m >> (8'd150 - e);
    endfunction

    logic [31:0] conv_q = '0;
    always @(posedge clk_i) if (cvt_en_o) conv_q <= conv_mag(cvt_din_o);
    assign cvt_dout_i = conv_q;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #3;
    endtask

    task automatic wait_ready(input int k);
        int waited;
        waited = 0;
        while (!req_ready_o[k] && waited < 50) begin
            tick();
            waited++;
        end
    endtask

    task automatic do_op(input int k, input logic [31:0] d, input logic [31:0] exp_d,
                         input logic exp_sat, input int exp_lat, input int exp_en, input string tag);
        int lat;
        int en;
        logic [N_REQ-1:0] oh;
        oh = '0;
        oh[k] = 1'b1;
        req_data_i[32*k +: 32] = d;
        req_valid_i[k] = 1'b1;
        #1;
        wait_ready(k);
        check_val({tag, "_accept"}, 32'(req_ready_o), 32'(oh));
        tick();
        req_valid_i[k] = 1'b0;
        lat = 1;
        en  = 0;
        while (!rsp_valid_o && lat < 400) begin
            en += int'(cvt_en_o);
            tick();
            lat++;
        end
        check_val({tag, "_lat"},  32'(lat), 32'(exp_lat));
        check_val({tag, "_data"}, rsp_data_o, exp_d);
        check_val({tag, "_id"},   32'(rsp_id_o), 32'(k));
        check_val({tag, "_sat"},  32'(rsp_sat_o), 32'(exp_sat));
        check_val({tag, "_en"},   32'(en), 32'(exp_en));
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        check_val({tag, "_done"}, 32'({rsp_valid_o, busy_o}), 32'd0);
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int idx;
        int g;
        int cyc;
        logic ok;
        logic pulse_ok;
        logic [N_REQ-1:0] prev;
        int got_ord [5];
        int exp_ord [5];

        // Reset state with all requesters pushing
        req_valid_i = '1;
        #12;
        check_val("rst_ready", 32'(req_ready_o), 32'd0);
        check_val("rst_flags", 32'({busy_o, cvt_en_o, rsp_valid_o, rsp_sat_o}), 32'd0);
        check_val("rst_data",  rsp_data_o, 32'd0);
        check_val("rst_din",   cvt_din_o, 32'd0);
        req_valid_i = '0;
        tick();
        rst_i = 1'b1;
        tick();

        do_op(0, 32'h4040_0000, 32'h0000_0003, 1'b0, 13, 10, "pos3");
        do_op(2, 32'hC0A0_0000, 32'hFFFF_FFFB, 1'b0, 13, 10, "neg5");
        do_op(1, 32'h3F00_0000, 32'h0000_0000, 1'b0, 2, 0, "half");
        do_op(3, 32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 2, 0, "inf");
        do_op(0, 32'hCF80_0000, 32'h8000_0000, 1'b1, 2, 0, "negbig");
        do_op(1, 32'h4B80_0000, 32'h0100_0000, 1'b0, 2, 0, "e151");
        do_op(2, 32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 2, 0, "e157");
        do_op(3, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 2, 0, "e158");
        do_op(0, 32'h4B7F_FFFF, 32'h00FF_FFFF, 1'b0, 13, 10, "e150");
        do_op(1, 32'hBF80_0000, 32'hFFFF_FFFF, 1'b0, 13, 10, "neg1");
        do_op(2, 32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 2, 0, "nan");

        // Back-pressure: response held 20 cycles while another requester waits
        req_data_i[31:0] = 32'h4B80_0000;
        req_valid_i[0] = 1'b1;
        #1;
        wait_ready(0);
        tick();
        req_valid_i[0] = 1'b0;
        req_data_i[95:64] = 32'h3F00_0000;
        req_valid_i[2] = 1'b1;
        lat = 0;
        while (!rsp_valid_o && lat < 50) begin
            tick();
            lat++;
        end
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'h0100_0000 || rsp_id_o !== 2'd0 ||
                rsp_sat_o !== 1'b0 || req_ready_o !== '0)
                ok = 1'b0;
            tick();
        end
        check_val("bp_stable", 32'(ok), 32'd1);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        check_val("bp_next_accept", 32'(req_ready_o), 32'h4);
        tick();
        req_valid_i[2] = 1'b0;
        lat = 0;
        while (!rsp_valid_o && lat < 50) begin
            tick();
            lat++;
        end
        check_val("bp2_data", rsp_data_o, 32'd0);
        check_val("bp2_id",   32'(rsp_id_o), 32'd2);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;

        // Fairness from a fresh pointer
        do_reset();
        exp_ord = '{0, 1, 2, 3, 0};
        got_ord = '{-1, -1, -1, -1, -1};
        for (int i = 0; i < N_REQ; i++) req_data_i[32*i +: 32] = 32'h3F00_0000;
        rsp_ready_i = 1'b1;
        req_valid_i = '1;
        #1;
        idx = 0;
        prev = '0;
        pulse_ok = 1'b1;
        cyc = 0;
        while (idx < 5 && cyc < 60) begin
            if (req_ready_o != '0) begin
                if (!$onehot(req_ready_o) || prev != '0) pulse_ok = 1'b0;
                g = -1;
                for (int j = 0; j < N_REQ; j++) if (req_ready_o[j]) g = j;
                got_ord[idx] = g;
                idx++;
            end
            prev = req_ready_o;
            tick();
            cyc++;
        end
        req_valid_i = '0;
        check_val("rr_count", 32'(idx), 32'd5);
        check_val("rr_pulse", 32'(pulse_ok), 32'd1);
        for (int i = 0; i < 5; i++) check_val($sformatf("rr_order%0d", i), 32'(got_ord[i]), 32'(exp_ord[i]));
        cyc = 0;
        while (busy_o && cyc < 20) begin
            tick();
            cyc++;
        end
        rsp_ready_i = 1'b0;
        check_val("rr_idle", 32'(busy_o), 32'd0);

        // Reset in the 5th converter cycle
        req_data_i[63:32] = 32'h4040_0000;
        req_valid_i[1] = 1'b1;
        #1;
        wait_ready(1);
        tick();
        req_valid_i[1] = 1'b0;
        repeat (5) tick();
        check_val("rc_en_before", 32'(cvt_en_o), 32'd1);
        #1;
        rst_i = 1'b0;
        req_valid_i[1] = 1'b1;
        #1;
        check_val("rc_flags", 32'({cvt_en_o, busy_o, rsp_valid_o, rsp_sat_o}), 32'd0);
        check_val("rc_ready", 32'(req_ready_o), 32'd0);
        check_val("rc_din",   cvt_din_o, 32'd0);
        check_val("rc_data",  rsp_data_o, 32'd0);
        tick();
        req_valid_i[1] = 1'b0;
        rst_i = 1'b1;
        tick();
        do_op(1, 32'h4040_0000, 32'h0000_0003, 1'b0, 13, 10, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_int_arb.md
FP_INT_ARB -- requirements
Module: fp_int_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one fp_int converter.
REQ-002 SHALL have parameter CONV_LAT, default 10, cycles cvt_en_o is held high before the converter result is sampled; legal range 2..255.
REQ-003 SHALL have these ports, one clock; reset is asynchronous and active-low:
  clk_i  in  1  clock, all state on rising edge
  rst_i  in  1  asynchronous, active-low reset
  req_valid_i  in  N_REQ  per-requester operand valid
  req_data_i  in  32*N_REQ  IEEE-754 single operands, requester k at [32k+31:32k]
  req_ready_o  out  N_REQ  one-hot accept strobe
  rsp_valid_o  out  1  result valid
  rsp_ready_i  in  1  result consumer ready
  rsp_id_o  out  $clog2(N_REQ)  requester index of result
  rsp_data_o  out  32  signed two's-complement integer result
  rsp_sat_o  out  1  result saturated (Inf/NaN/overflow)
  cvt_en_o  out  1  shared converter enable
  cvt_din_o  out  32  shared converter operand
  cvt_dout_i  in  32  converter magnitude result
  busy_o  out  1  FSM not in IDLE

Function
REQ-004 SHALL implement FSM states IDLE, CLASS, CONV, CAPT, RESP.
REQ-005 IDLE: if any req_valid_i bit set, SHALL pick a winner round-robin starting at pointer rr_ptr, pulse req_ready_o[winner] for that single cycle, latch operand and id, go to CLASS; otherwise stay in IDLE.
REQ-006 req_ready_o SHALL be all-zero in every state except the IDLE accept cycle; at most one bit SHALL be set.
REQ-007 CLASS: with e = exponent field, s = sign, m = {1, mantissa}:
  e == 255 or e >= 158 -> result = s ? 32'h8000_0000 : 32'h7FFF_FFFF, sat = 1, go to RESP;
  e < 127 -> result 0, sat 0, go to RESP;
  151 <= e <= 157 -> result = m << (e-150), negated if s, sat 0, go to RESP (no converter use);
  127 <= e <= 150 -> go to CONV.
REQ-008 CONV: cvt_en_o = 1 and cvt_din_o = latched operand for exactly CONV_LAT consecutive cycles, counted by an internal counter; then go to CAPT.
REQ-009 CAPT: cvt_en_o = 0; SHALL sample cvt_dout_i, two's-complement negate if s, sat 0, go to RESP.
REQ-010 cvt_en_o SHALL be 0 in every state except CONV; cvt_din_o SHALL be 0 outside CONV.
REQ-011 RESP: rsp_valid_o = 1; rsp_data_o, rsp_id_o and rsp_sat_o SHALL hold stable until rsp_ready_i is high; on that cycle go to IDLE and set rr_ptr = (id+1) mod N_REQ.
REQ-012 Latency, measured from the accept cycle (cycle 0): bypass classes SHALL raise rsp_valid_o in cycle 2; the converter class SHALL raise it in cycle CONV_LAT+3.
REQ-013 No new request SHALL be accepted until the current response handshake completes; throughput is one operation in flight.
REQ-014 rsp_valid_o SHALL be 0 outside RESP; rsp_data_o, rsp_id_o and rsp_sat_o SHALL be 0 outside RESP.
REQ-015 A requester dropping req_valid_i before its accept strobe SHALL simply lose arbitration; no state SHALL be altered.
REQ-016 Fairness: with all requesters continuously valid, each SHALL be served once in every N_REQ consecutive operations.

Reset
REQ-017 While rst_i = 0, asynchronously: FSM = IDLE, rr_ptr = 0, counter = 0, all latched data = 0, and every output = 0.
REQ-018 Reset asserted mid-CONV or mid-RESP SHALL drop cvt_en_o and rsp_valid_o immediately; the in-flight operation is discarded.
REQ-019 The first accept after reset release SHALL occur no earlier than the first rising edge with rst_i = 1.

Structure
REQ-020 The shared package fp_int_pkg SHALL hold the state enum, exponent thresholds (127, 150, 157, 158, 255) and the saturation constants.
REQ-021 Round-robin selection SHALL be one sub-module, rr_arb, taking request vector and pointer and returning a one-hot grant plus valid.

Verification
REQ-022 Requester 0 sends 0x40400000 (3.0), CONV_LAT = 10 -> cvt_en_o high for 10 cycles; rsp_data_o = 3, id 0, sat 0, rsp_valid_o in cycle 13.
REQ-023 Requester 2 sends 0xC0A00000 (-5.0) -> rsp_data_o = 0xFFFFFFFB, id 2, sat 0.
REQ-024 Bypass operands 0x3F000000 -> 0; 0x7F800000 -> 0x7FFFFFFF with sat 1; 0xCF800000 -> 0x80000000 with sat 1; 0x4B800000 -> 0x01000000. Each response is valid in cycle 2, and cvt_en_o never rises.
REQ-025 All four requesters valid continuously -> grants issued in order 0, 1, 2, 3, 0, with each req_ready_o bit a one-cycle pulse.
REQ-026 Hold rsp_ready_i low for 20 cycles in RESP -> outputs stay stable and no new req_ready_o pulse occurs; when rsp_ready_i rises, FSM returns to IDLE and the next accept happens in the following cycle.
REQ-027 Assert rst_i low in the 5th cycle of CONV -> cvt_en_o, busy_o and all outputs go to 0 immediately; after release, 0x40400000 from requester 1 converts correctly to 3.
